// File: rtl/ans_ht_ltf_cp_streamer.sv
// HT-LTF cyclic-prefix streamer: boots the HT-LTF generator, captures one 64-sample
// symbol into a local buffer, then replays it n times with a 16-sample guard interval.
// Symbol 1 is negated with saturation.
module ans_ht_ltf_cp_streamer #(
  parameter int unsigned TIMEOUT_CYCLES = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  num_ltf,
  output logic        gen_boot,
  input  logic        gen_ready,
  output logic        gen_output_enabled,
  input  logic [31:0] gen_sample,
  output logic [31:0] out_sample,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        err_timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle, StBoot, StWaitGen, StCapture, StEmit, StError
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [6:0]    cnt_q, cnt_d;      // capture cycle index, then emit sample index
  logic [1:0]    sym_q, sym_d;
  logic [1:0]    nlast_q, nlast_d;  // number of symbols minus one
  logic          err_q, err_d;
  logic [31:0]   out_sample_q, out_sample_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [31:0]   buf_q [64];
  logic [6:0]    emit_addr;
  logic [31:0]   buf_word;

  function automatic logic [15:0] sat_neg(input logic [15:0] x);
    return (x == 16'h8000) ? 16'h7fff : (~x + 16'd1);
  endfunction

  // Next-state, counters and registered output stream.
  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    cnt_d        = cnt_q;
    sym_d        = sym_q;
    nlast_d      = nlast_q;
    err_d        = err_q;
    out_sample_d = 32'd0;
    out_valid_d  = 1'b0;
    out_last_d   = 1'b0;
    emit_addr    = 7'd0;
    buf_word     = 32'd0;
    unique case (state_q)
      StIdle, StError: begin
        if (start) begin
          state_d = StBoot;
          err_d   = 1'b0;
          if (num_ltf == 3'd0)      nlast_d = 2'd0;
          else if (num_ltf > 3'd4)  nlast_d = 2'd3;
          else                      nlast_d = 2'(num_ltf - 3'd1);
        end
      end
      StBoot: begin
        tmo_d   = '0;
        state_d = StWaitGen;
      end
      StWaitGen: begin
        if (gen_ready) begin
          state_d = StCapture;
          cnt_d   = 7'd0;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = StError;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StCapture: begin
        if (cnt_q == 7'd80) begin
          state_d = StEmit;
          cnt_d   = 7'd0;
          sym_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      StEmit: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            state_d = StIdle;
            cnt_d   = 7'd0;
            sym_d   = 2'd0;
          end else if (cnt_q == 7'd79) begin
            cnt_d = 7'd0;
            sym_d = sym_q + 2'd1;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Preload the sample the next cycle will present; holds while stalled.
    if (state_d == StEmit) begin
      emit_addr   = (cnt_d < 7'd16) ? (cnt_d + 7'd48) : (cnt_d - 7'd16);
      buf_word    = buf_q[emit_addr[5:0]];
      out_valid_d = 1'b1;
      out_last_d  = (cnt_d == 7'd79) && (sym_d == nlast_q);
      out_sample_d = (sym_d == 2'd1) ? {sat_neg(buf_word[31:16]), sat_neg(buf_word[15:0])}
                                     : buf_word;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      tmo_q        <= '0;
      cnt_q        <= 7'd0;
      sym_q        <= 2'd0;
      nlast_q      <= 2'd0;
      err_q        <= 1'b0;
      out_sample_q <= 32'd0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      cnt_q        <= cnt_d;
      sym_q        <= sym_d;
      nlast_q      <= nlast_d;
      err_q        <= err_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
    end
  end

  // Symbol buffer: first 64 enabled cycles are kept, the generator's tail is dropped.
  always_ff @(posedge clk) begin
    if (!reset && state_q == StCapture && cnt_q < 7'd64) begin
      buf_q[cnt_q[5:0]] <= gen_sample;
    end
  end

  assign gen_boot           = (state_q == StBoot);
  assign gen_output_enabled = (state_q == StCapture);
  assign busy               = (state_q != StIdle);
  assign err_timeout        = err_q;
  assign out_sample         = out_sample_q;
  assign out_valid          = out_valid_q;
  assign out_last           = out_last_q;

endmodule

// File: tb/tb_ans_ht_ltf_cp_streamer.sv
// Directed bench for the HT-LTF cyclic-prefix streamer with a behavioural generator.
module tb_ans_ht_ltf_cp_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  num_ltf = 3'd1;
  logic        gen_boot;
  logic        gen_ready = 1'b0;
  logic        gen_output_enabled;
  logic [31:0] gen_sample;
  logic [31:0] out_sample;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        busy;
  logic        err_timeout;

  int total = 0;
  int bad = 0;
  logic        mode = 1'b0;     // 0: ramp pattern, 1: constant {8000,0005}
  logic        hold_low = 1'b0; // generator never becomes ready
  logic [15:0] ecnt = 16'd0;
  logic [31:0] got0, got16, got80;

  ans_ht_ltf_cp_streamer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .num_ltf(num_ltf),
    .gen_boot(gen_boot), .gen_ready(gen_ready), .gen_output_enabled(gen_output_enabled),
    .gen_sample(gen_sample), .out_sample(out_sample), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Generator model: ready one cycle after boot, idle again after 81 enabled cycles.
  always @(posedge clk) begin
    if (gen_boot) begin
      ecnt      <= 16'd0;
      gen_ready <= ~hold_low;
    end else if (gen_output_enabled) begin
      ecnt <= ecnt + 16'd1;
      if (ecnt == 16'd80) gen_ready <= 1'b0;
    end
  end

  assign gen_sample = mode ? 32'h8000_0005 :
                      (ecnt < 16'd64) ? {ecnt, 16'h0100 + ecnt} : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] neg_sat(input logic [15:0] x);
    logic [15:0] r;
    if (x == 16'h8000) r = 16'h7fff;
    else r = 16'h0000 - x;
    return r;
  endfunction

  function automatic logic [31:0] exp_sample(input int sym, input int idx);
    int k;
    logic [15:0] kk;
    logic [31:0] s;
    k = (idx < 16) ? idx + 48 : idx - 16;
    kk = 16'(k);
    s = mode ? 32'h8000_0005 : {kk, 16'h0100 + kk};
    if (sym == 1) s = {neg_sat(s[31:16]), neg_sat(s[15:0])};
    return s;
  endfunction

  task automatic do_start(input logic [2:0] n);
    @(negedge clk);
    start = 1'b1;
    num_ltf = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Collect the stream; expects n symbols, optional stray start pulse at sample pulse_at.
  task automatic run_emit(input int n, input bit rnd, input int pulse_at);
    int acc = 0;
    int cyc = 0;
    bit prev_stall = 0;
    bit pulsed = 0;
    logic [31:0] prev = 32'd0;
    while (acc < n * 80 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pulse_at >= 0 && acc == pulse_at && !pulsed) begin
        start = 1'b1;
        pulsed = 1;
      end else begin
        start = 1'b0;
      end
      if (prev_stall) chk("stall_stable", out_sample, prev);
      if (out_valid && out_ready) begin
        chk("sample", out_sample, exp_sample(acc / 80, acc % 80));
        chk("last", 32'(out_last), 32'(acc == n * 80 - 1));
        if (acc == 0) got0 = out_sample;
        if (acc == 16) got16 = out_sample;
        if (acc == 80) got80 = out_sample;
        acc++;
      end
      prev_stall = out_valid && !out_ready;
      prev = out_sample;
    end
    start = 1'b0;
    chk("count", 32'(acc), 32'(n * 80));
    @(negedge clk);
    out_ready = 1'b1;
    chk("busy_after", 32'(busy), 32'd0);
    chk("valid_after", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_boot", 32'(gen_boot), 32'd0);
    chk("rst_oe", 32'(gen_output_enabled), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_sample", out_sample, 32'd0);

    // Ramp pattern, single symbol.
    do_start(3'd1);
    chk("boot_pulse", 32'(gen_boot), 32'd1);
    @(negedge clk);
    chk("boot_one_cycle", 32'(gen_boot), 32'd0);
    run_emit(1, 1'b0, -1);
    chk("first_sample", got0, {16'd48, 16'h0130});
    chk("sample_17", got16, {16'd0, 16'h0100});

    // Saturating negation of symbol 1.
    mode = 1'b1;
    do_start(3'd2);
    run_emit(2, 1'b0, -1);
    chk("sym0_plain", got0, 32'h8000_0005);
    chk("sym1_neg", got80, 32'h7FFF_FFFB);

    // Random backpressure, four symbols.
    mode = 1'b0;
    do_start(3'd4);
    run_emit(4, 1'b1, -1);

    // Clamp: 0 -> 1 symbol, 7 -> 4 symbols with a stray start during EMIT.
    do_start(3'd0);
    run_emit(1, 1'b0, -1);
    do_start(3'd7);
    run_emit(4, 1'b0, 100);

    // Generator never ready: ERROR after 16 WAIT_GEN cycles.
    hold_low = 1'b1;
    do_start(3'd1);
    c = 0;
    while (!err_timeout && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("timeout_cycles", 32'(c), 32'd17);
    chk("err_busy", 32'(busy), 32'd1);
    chk("err_valid", 32'(out_valid), 32'd0);
    chk("err_oe", 32'(gen_output_enabled), 32'd0);
    hold_low = 1'b0;
    do_start(3'd1);
    chk("err_cleared", 32'(err_timeout), 32'd0);
    run_emit(1, 1'b0, -1);

    // Reset in capture cycle 30, with start held alongside reset.
    do_start(3'd2);
    c = 0;
    while (!(gen_output_enabled && ecnt == 16'd30) && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("reach_cap30", 32'(ecnt), 32'd30);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("rst_cap_oe", 32'(gen_output_enabled), 32'd0);
    chk("rst_cap_busy", 32'(busy), 32'd0);
    chk("rst_cap_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_start_ignored", 32'(busy), 32'd0);
    do_start(3'd1);
    run_emit(1, 1'b0, -1);
    chk("post_rst_first", got0, {16'd48, 16'h0130});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
